// File: rtl/merge_pkg.sv
// Shared types and helpers for the N-input buffered merge.
// MERGE_N_BUF_TAG_EN adds the source index to each buffered word.
package merge_pkg;

   localparam int MERGE_MAX_IN = 16;
   localparam int MERGE_SELW   = $clog2(MERGE_MAX_IN);

   typedef logic [MERGE_SELW-1:0] sel_t;

   function automatic logic sel_out_of_range(input sel_t s, input int num_in);
      return int'(s) >= num_in;
   endfunction

   function automatic int tag_width(input int selw);
`ifdef MERGE_N_BUF_TAG_EN
      return selw;
`else
      return 0;
`endif
   endfunction

endpackage

// File: rtl/merge_sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is read combinationally.
module merge_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // When empty, keep presenting the most recently read slot rather than the next write slot.
   assign dout = empty ? mem[rd_ptr - AW'(1)] : mem[rd_ptr];

endmodule

// File: rtl/merge_n_buf.sv
// Select-steered merge of NUM_IN valid/ready streams into a buffered output.
// MERGE_N_BUF_TAG_EN: each output word carries its source index in the MSBs.
module merge_n_buf
   import merge_pkg::*;
#(
   parameter int WIDTH  = 33,
   parameter int NUM_IN = 4,
   parameter int DEPTH  = 4,
   parameter int SELW   = $clog2(NUM_IN)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_IN-1:0]                   in_valid,
   output logic [NUM_IN-1:0]                   in_ready,
   input  logic [NUM_IN*WIDTH-1:0]             in_data,
   input  logic                                sel_valid,
   output logic                                sel_ready,
   input  logic [SELW-1:0]                     sel_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [WIDTH+tag_width(SELW)-1:0]    out_data,
   output logic [$clog2(DEPTH):0]              count,
   output logic                                err_sel
);

   localparam int OW = WIDTH + tag_width(SELW);

   logic             full;
   logic             empty;
   logic             sel_oor;
   logic             push;
   logic [WIDTH-1:0] sel_word;
   logic [OW-1:0]    fifo_din;

   assign sel_oor = sel_out_of_range(sel_t'(sel_data), NUM_IN);

   // Readies are held low during reset so no transfer can straddle it.
   always_comb begin
      in_ready  = '0;
      sel_ready = 1'b0;
      sel_word  = '0;
      if (rst_n) begin
         if (sel_oor) begin
            sel_ready = sel_valid;
         end else begin
            for (int i = 0; i < NUM_IN; i++) begin
               if (sel_data == SELW'(i)) begin
                  in_ready[i] = sel_valid & in_valid[i] & ~full;
                  sel_ready   = sel_valid & in_valid[i] & ~full;
                  sel_word    = in_data[i*WIDTH +: WIDTH];
               end
            end
         end
      end
   end

   assign push = |in_ready;

`ifdef MERGE_N_BUF_TAG_EN
   assign fifo_din = {sel_data, sel_word};
`else
   assign fifo_din = sel_word;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  err_sel <= 1'b0;
      else if (sel_valid & sel_oor) err_sel <= 1'b1;
   end

   merge_sync_fifo #(
      .WIDTH (OW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (fifo_din),
      .pop   (out_ready),
      .dout  (out_data),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign out_valid = ~empty;

endmodule

// File: tb/tb_merge_n_buf.sv
// Bench for merge_n_buf (NUM_IN=3, WIDTH=33, DEPTH=4): ready vector table plus output scoreboard.
module tb_merge_n_buf;

   localparam int WIDTH  = 33;
   localparam int NUM_IN = 3;
   localparam int DEPTH  = 4;
`ifdef MERGE_N_BUF_TAG_EN
   localparam int OW = WIDTH + 2;
`else
   localparam int OW = WIDTH;
`endif

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic [NUM_IN-1:0]       in_valid = '0;
   logic [NUM_IN-1:0]       in_ready;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic                    sel_valid = 1'b0;
   logic                    sel_ready;
   logic [1:0]              sel_data = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [OW-1:0]           out_data;
   logic [2:0]              count;
   logic                    err_sel;

   logic [WIDTH-1:0] d [NUM_IN];
   assign in_data = {d[2], d[1], d[0]};

   always #5 clk = ~clk;

   merge_n_buf #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sel_valid (sel_valid),
      .sel_ready (sel_ready),
      .sel_data  (sel_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .err_sel   (err_sel)
   );

   int            checks = 0;
   int            failures = 0;
   logic [OW-1:0] q [$];
   bit            merr = 1'b0;

   typedef struct {
      logic [2:0]       iv;
      logic [WIDTH-1:0] d0;
      logic [WIDTH-1:0] d1;
      logic [WIDTH-1:0] d2;
      logic             sv;
      logic [1:0]       sel;
      logic [2:0]       e_ir;
      logic             e_sr;
   } vec_t;

   vec_t tbl [8];

   function automatic logic [OW-1:0] exp_word(input logic [1:0] s, input logic [WIDTH-1:0] w);
`ifdef MERGE_N_BUF_TAG_EN
      return {s, w};
`else
      return w;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock: predict and compare at the falling edge, update the model at the rising edge.
   task automatic cycle(output logic [2:0] ir_s, output logic sr_s, output bit acc);
      logic [2:0] e_ir;
      logic       e_sr;
      @(negedge clk);
      e_ir = '0;
      e_sr = 1'b0;
      if (rst_n) begin
         if (sel_data == 2'd3) begin
            e_sr = sel_valid;
         end else begin
            e_ir[sel_data] = sel_valid & in_valid[sel_data] & (q.size() < DEPTH);
            e_sr = e_ir[sel_data];
         end
      end
      check("in_ready", 64'(in_ready), 64'(e_ir));
      check("sel_ready", 64'(sel_ready), 64'(e_sr));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("count", 64'(count), 64'(q.size()));
      check("err_sel", 64'(err_sel), 64'(merr));
      if (q.size() != 0) check("out_data", 64'(out_data), 64'(q[0]));
      ir_s = in_ready;
      sr_s = sel_ready;
      acc  = |e_ir;
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         merr = 1'b0;
      end else begin
         if (out_ready && q.size() != 0) void'(q.pop_front());
         if (|e_ir) q.push_back(exp_word(sel_data, d[sel_data]));
         if (sel_valid && sel_data == 2'd3) merr = 1'b1;
      end
      #1;
   endtask

   initial begin
      logic [2:0] ir;
      logic       sr;
      bit         acc;
      bit         got;

      tbl[0] = '{3'b011, 33'd5, 33'd40, 33'd0, 1'b1, 2'd1, 3'b010, 1'b1};
      tbl[1] = '{3'b011, 33'd5, 33'd40, 33'd0, 1'b1, 2'd0, 3'b001, 1'b1};
      tbl[2] = '{3'b100, 33'd7, 33'd8, 33'd9, 1'b1, 2'd1, 3'b000, 1'b0};
      tbl[3] = '{3'b000, 33'd7, 33'd8, 33'd9, 1'b0, 2'd2, 3'b000, 1'b0};
      tbl[4] = '{3'b111, 33'd1, 33'd2, 33'd3, 1'b1, 2'd2, 3'b100, 1'b1};
      tbl[5] = '{3'b111, 33'd1, 33'd2, 33'd3, 1'b0, 2'd0, 3'b000, 1'b0};
      tbl[6] = '{3'b101, 33'h1_FFFF_FFFF, 33'd2, 33'h0_AAAA_5555, 1'b1, 2'd0, 3'b001, 1'b1};
      tbl[7] = '{3'b010, 33'd0, 33'h1_0000_0007, 33'd0, 1'b1, 2'd1, 3'b010, 1'b1};

      for (int i = 0; i < NUM_IN; i++) d[i] = '0;

      // Reset: readies forced low even with everything offered.
      rst_n = 1'b0; sel_valid = 1'b1; in_valid = 3'b111; sel_data = 2'd1; out_ready = 1'b1;
      cycle(ir, sr, acc);
      check("reset_in_ready", 64'(ir), 64'(0));
      cycle(ir, sr, acc);
      rst_n = 1'b1; sel_valid = 1'b0;
      cycle(ir, sr, acc);
      check("idle_in_ready", 64'(ir), 64'(0));

      // Table: readies per row, data through the scoreboard.
      for (int r = 0; r < 8; r++) begin
         in_valid = tbl[r].iv; d[0] = tbl[r].d0; d[1] = tbl[r].d1; d[2] = tbl[r].d2;
         sel_valid = tbl[r].sv; sel_data = tbl[r].sel;
         cycle(ir, sr, acc);
         check($sformatf("tbl%0d_in_ready", r), 64'(ir), 64'(tbl[r].e_ir));
         check($sformatf("tbl%0d_sel_ready", r), 64'(sr), 64'(tbl[r].e_sr));
      end
      sel_valid = 1'b0;
      cycle(ir, sr, acc);
      cycle(ir, sr, acc);

      // Full: four tokens fill the buffer, later tokens wait.
      out_ready = 1'b0; in_valid = 3'b111; sel_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sel_data = 2'(k % 3);
         d[0] = 33'h100 + 33'(k); d[1] = 33'h200 + 33'(k); d[2] = 33'h1_0000_0300 + 33'(k);
         cycle(ir, sr, acc);
         check("full_accept", 64'(acc), 64'(1));
      end
      check("full_count", 64'(count), 64'(4));
      sel_data = 2'd1; d[1] = 33'h0_DEAD_0004;
      cycle(ir, sr, acc);
      check("full_sel_ready", 64'(sr), 64'(0));
      cycle(ir, sr, acc);
      check("full_sel_ready2", 64'(sr), 64'(0));
      out_ready = 1'b1;
      cycle(ir, sr, acc);
      check("full_bubble", 64'(sr), 64'(0));
      cycle(ir, sr, acc);
      check("full_resume", 64'(sr), 64'(1));
      sel_data = 2'd2; d[2] = 33'h1_BEEF_0005;
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) cycle(ir, sr, got);
      check("token6_accept", 64'(got), 64'(1));
      sel_valid = 1'b0;
      for (int t = 0; t < 10 && q.size() != 0; t++) cycle(ir, sr, acc);
      check("drain_count", 64'(count), 64'(0));

      // Missing data on the selected input.
      in_valid = 3'b011; sel_valid = 1'b1; sel_data = 2'd2; d[2] = 33'h0_0000_1234;
      for (int t = 0; t < 3; t++) begin
         cycle(ir, sr, acc);
         check("missing_sel_ready", 64'(sr), 64'(0));
      end
      in_valid = 3'b111;
      cycle(ir, sr, acc);
      check("missing_accept", 64'(sr), 64'(1));
      sel_valid = 1'b0;
      cycle(ir, sr, acc);

      // Out-of-range select: consumed, no push, sticky error.
      out_ready = 1'b0; sel_valid = 1'b1; sel_data = 2'd0; d[0] = 33'd77;
      cycle(ir, sr, acc);
      sel_data = 2'd3;
      cycle(ir, sr, acc);
      check("oor_sel_ready", 64'(sr), 64'(1));
      check("oor_in_ready", 64'(ir), 64'(0));
      check("oor_count", 64'(count), 64'(1));
      sel_valid = 1'b0;
      cycle(ir, sr, acc);
      check("oor_err", 64'(err_sel), 64'(1));
      out_ready = 1'b1;
      cycle(ir, sr, acc);
      cycle(ir, sr, acc);
      check("oor_err_sticky", 64'(err_sel), 64'(1));

      // Asynchronous reset mid-stream with three words buffered.
      out_ready = 1'b0; sel_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sel_data = 2'(k); d[k] = 33'h55 + 33'(k);
         cycle(ir, sr, acc);
      end
      sel_valid = 1'b0;
      check("pre_reset_count", 64'(count), 64'(3));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_count", 64'(count), 64'(0));
      check("async_out_valid", 64'(out_valid), 64'(0));
      check("async_err_sel", 64'(err_sel), 64'(0));
      q.delete();
      merr = 1'b0;
      sel_valid = 1'b1; sel_data = 2'd0;
      cycle(ir, sr, acc);
      rst_n = 1'b1; sel_valid = 1'b0; out_ready = 1'b1;
      cycle(ir, sr, acc);
      sel_valid = 1'b1; sel_data = 2'd1; d[1] = 33'h1_0000_0007;
      cycle(ir, sr, acc);
      sel_valid = 1'b0;
      cycle(ir, sr, acc);
      cycle(ir, sr, acc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
